// File: rtl/firebird_pc_ctrl.sv
// firebird_pc_ctrl: fetch/commit sequencer for the firebird_pc register.
// Runs the instruction-memory fetch handshake and picks the next PC:
// sequential, branch, jump or trap vector.
// Optional build macro FIREBIRD_PC_CTRL_TRACE_EN adds retire_cnt/retire_pc.
module firebird_pc_ctrl #(
   parameter int unsigned         PC_W         = 32,
   parameter logic [PC_W-1:0]     RESET_VECTOR = PC_W'(32'h0000_0000),
   parameter logic [PC_W-1:0]     TRAP_VECTOR  = PC_W'(32'h0000_0100)
) (
   input  logic            clk,
   input  logic            pc_ctrl_reset_n,
   input  logic [PC_W-1:0] cur_pc,
   output logic [PC_W-1:0] new_address,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     instr_o,
   output logic            instr_valid,
   input  logic            exec_stall,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   input  logic            jump,
   input  logic [PC_W-1:0] jump_target,
   input  logic            illegal,
   input  logic            irq,
   output logic            trap_valid,
   output logic [1:0]      trap_cause,
   output logic [PC_W-1:0] trap_epc
`ifdef FIREBIRD_PC_CTRL_TRACE_EN
   ,
   output logic [31:0]     retire_cnt,
   output logic [PC_W-1:0] retire_pc
`endif
);

   typedef enum logic [1:0] {BOOT, FETCH, COMMIT} state_t;

   state_t          state, state_nxt;
   logic            irq_pend;
   logic [PC_W-1:0] target;
   logic            misaligned;
   logic [1:0]      cause_d;
   logic            commit_go;
   logic            trap_take;

   assign imem_addr = cur_pc;

   // Redirect target and trap classification for the instruction in COMMIT
   always_comb begin
      if (jump)
         target = jump_target;
      else if (branch_taken)
         target = branch_target;
      else
         target = cur_pc + PC_W'(4);
      misaligned = (jump | branch_taken) & (target[1:0] != 2'b00);
      if (illegal)
         cause_d = 2'd1;
      else if (misaligned)
         cause_d = 2'd2;
      else if (irq_pend)
         cause_d = 2'd3;
      else
         cause_d = 2'd0;
      commit_go = (state == COMMIT) & ~exec_stall;
      trap_take = commit_go & (cause_d != 2'd0);
   end

   // State register
   always_ff @(posedge clk) begin
      if (!pc_ctrl_reset_n)
         state <= BOOT;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         BOOT:    state_nxt = FETCH;
         FETCH:   if (imem_ack) state_nxt = COMMIT;
         COMMIT:  if (!exec_stall) state_nxt = FETCH;
         default: state_nxt = BOOT;
      endcase
   end

   // State-decoded outputs and next PC selection
   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      new_address = cur_pc;
      unique case (state)
         BOOT:    new_address = RESET_VECTOR;
         FETCH:   imem_req = 1'b1;
         COMMIT: begin
            instr_valid = 1'b1;
            if (!exec_stall)
               new_address = (cause_d != 2'd0) ? TRAP_VECTOR : target;
         end
         default: new_address = cur_pc;
      endcase
   end

   // Instruction latch, trap reporting and pending interrupt
   always_ff @(posedge clk) begin
      if (!pc_ctrl_reset_n) begin
         instr_o    <= '0;
         irq_pend   <= 1'b0;
         trap_valid <= 1'b0;
         trap_cause <= '0;
         trap_epc   <= '0;
      end else begin
         if (state == FETCH && imem_ack)
            instr_o <= imem_rdata;
         // irq arriving in the clearing cycle keeps the request pending
         irq_pend   <= irq | (irq_pend & ~(trap_take & (cause_d == 2'd3)));
         trap_valid <= trap_take;
         if (trap_take) begin
            trap_cause <= cause_d;
            trap_epc   <= (cause_d == 2'd3) ? target : cur_pc;
         end
      end
   end

`ifdef FIREBIRD_PC_CTRL_TRACE_EN
   // Retirement trace: plain commits and irq traps retire the instruction
   always_ff @(posedge clk) begin
      if (!pc_ctrl_reset_n) begin
         retire_cnt <= '0;
         retire_pc  <= '0;
      end else if (commit_go && (cause_d == 2'd0 || cause_d == 2'd3)) begin
         retire_cnt <= retire_cnt + 32'd1;
         retire_pc  <= cur_pc;
      end
   end
`endif

endmodule

// File: tb/tb_firebird_pc_ctrl.sv
// Self-checking bench for firebird_pc_ctrl: directed scenarios followed by
// random stimulus, all checked cycle by cycle against a behavioural model.
module tb_firebird_pc_ctrl;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] cur_pc;
   logic [31:0] new_address, imem_addr, instr_o, trap_epc;
   logic        imem_req, instr_valid, trap_valid;
   logic [1:0]  trap_cause;
   logic        imem_ack, exec_stall, branch_taken, jump, illegal, irq;
   logic [31:0] imem_rdata, branch_target, jump_target;
`ifdef FIREBIRD_PC_CTRL_TRACE_EN
   logic [31:0] retire_cnt, retire_pc;
`endif

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   firebird_pc_ctrl #(.PC_W(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
      .clk(clk), .pc_ctrl_reset_n(rst_n), .cur_pc(cur_pc),
      .new_address(new_address), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_o(instr_o),
      .instr_valid(instr_valid), .exec_stall(exec_stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .illegal(illegal), .irq(irq),
      .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_epc(trap_epc)
`ifdef FIREBIRD_PC_CTRL_TRACE_EN
      , .retire_cnt(retire_cnt), .retire_pc(retire_pc)
`endif
   );

   // Stand-in for firebird_pc: loads new_address, cleared by pc_reset
   always @(posedge clk) begin
      if (!rst_n) cur_pc <= '0;
      else        cur_pc <= new_address;
   end

   // Reference model state
   bit          m_known = 0;
   bit          m_booting, m_fetching, m_have, m_irqp;
   logic [31:0] m_pc, m_instr, m_te, m_rcnt, m_rpc;
   logic [1:0]  m_tc;
   bit          m_tv;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic idle_inputs();
      imem_ack = 1'b0; imem_rdata = $urandom; exec_stall = 1'b0;
      branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;
      illegal = 1'b0; irq = 1'b0;
   endtask

   // One clock: compare outputs against the model, advance model, advance clock
   task automatic step();
      logic [31:0] e_na, tgt;
      logic [1:0]  cause;
      bit          retire;
      #1;
      cause  = 2'd0;
      tgt    = m_pc + 32'd4;
      retire = 0;
      if (m_booting)                 e_na = RV;
      else if (m_fetching)           e_na = m_pc;
      else if (m_have && exec_stall) e_na = m_pc;
      else begin
         if (jump)              tgt = jump_target;
         else if (branch_taken) tgt = branch_target;
         if (illegal)                                   cause = 2'd1;
         else if ((jump || branch_taken) && tgt % 4 != 0) cause = 2'd2;
         else if (m_irqp)                               cause = 2'd3;
         e_na   = (cause != 0) ? TV : tgt;
         retire = (cause == 0 || cause == 3);
      end
      if (m_known) begin
         check("imem_req",    imem_req,    m_fetching);
         check("imem_addr",   imem_addr,   m_pc);
         check("instr_valid", instr_valid, m_have);
         check("new_address", new_address, e_na);
         check("instr_o",     instr_o,     m_instr);
         check("trap_valid",  trap_valid,  m_tv);
         check("trap_cause",  trap_cause,  m_tc);
         check("trap_epc",    trap_epc,    m_te);
`ifdef FIREBIRD_PC_CTRL_TRACE_EN
         check("retire_cnt",  retire_cnt,  m_rcnt);
         check("retire_pc",   retire_pc,   m_rpc);
`endif
      end
      if (!rst_n) begin
         m_known = 1; m_booting = 1; m_fetching = 0; m_have = 0; m_irqp = 0;
         m_pc = '0; m_instr = '0; m_tv = 0; m_tc = '0; m_te = '0;
         m_rcnt = '0; m_rpc = '0;
      end else if (m_known) begin
         m_pc = e_na;
         m_tv = 0;
         if (m_have && !exec_stall) begin
            m_tv = (cause != 0);
            if (cause != 0) begin
               m_tc = cause;
               m_te = (cause == 3) ? tgt : imem_addr;
            end
            if (retire) begin m_rcnt = m_rcnt + 1; m_rpc = imem_addr; end
         end
         m_irqp = irq || (m_irqp && !(m_have && !exec_stall && cause == 3));
         if (m_booting) begin
            m_booting = 0; m_fetching = 1;
         end else if (m_fetching && imem_ack) begin
            m_fetching = 0; m_have = 1; m_instr = imem_rdata;
         end else if (m_have && !exec_stall) begin
            m_have = 0; m_fetching = 1;
         end
      end
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   // Steps with immediate acks until the model holds an instruction in COMMIT
   task automatic to_commit();
      int n = 0;
      while (!m_have && n < 20) begin
         imem_ack = 1'b1;
         step();
         n++;
      end
      if (!m_have) begin
         n_checks++; n_err++;
         $display("FAIL to_commit: no commit within 20 cycles");
      end
   endtask

   function automatic logic [31:0] rand_target();
      int unsigned r = $urandom_range(0, 9);
      if (r == 0) return 32'hFFFF_FFFC;
      if (r == 1) return ($urandom & 32'h0000_0FFC) | $urandom_range(1, 3);
      return $urandom & 32'h0000_0FFC;
   endfunction

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      @(posedge clk); #1;
      step(); step();
      rst_n = 1'b1;
      // Plain sequential stream with acks right after each request
      for (int i = 0; i < 9; i++) begin imem_ack = 1'b1; step(); end
      // jump wins over branch in the same commit
      to_commit();
      branch_taken = 1'b1; branch_target = 32'h40; jump = 1'b1; jump_target = 32'h80;
      step();
      check("jump_priority_addr", imem_addr, 32'h80);
      // Misaligned jump target
      to_commit();
      jump = 1'b1; jump_target = 32'h42;
      step();
      check("misaligned_trap", {trap_valid, trap_cause}, {1'b1, 2'd2});
      // irq pulsed during fetch, taken at the plain commit
      step();
      irq = 1'b1; step();
      to_commit(); step();
      // Illegal with a pending irq, then the irq on the next commit
      irq = 1'b1; step();
      to_commit(); illegal = 1'b1; step();
      to_commit(); step();
      // Execute stall held for three cycles
      to_commit();
      for (int i = 0; i < 3; i++) begin exec_stall = 1'b1; step(); end
      step();
      // Wrap of the sequential add at the top of the address space
      to_commit(); jump = 1'b1; jump_target = 32'hFFFF_FFFC; step();
      to_commit(); step();
      check("wrap_addr", imem_addr, 32'h0);
      // Reset mid-fetch with a late ack
      step();
      rst_n = 1'b0; step();
      rst_n = 1'b1; imem_ack = 1'b1; step();
      check("reset_first_fetch", imem_addr, RV);
      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rst_n         = ($urandom_range(0, 199) != 0);
         imem_ack      = ($urandom_range(0, 1) == 1);
         imem_rdata    = $urandom;
         exec_stall    = ($urandom_range(0, 3) == 0);
         branch_taken  = ($urandom_range(0, 3) == 0);
         branch_target = rand_target();
         jump          = ($urandom_range(0, 5) == 0);
         jump_target   = rand_target();
         illegal       = ($urandom_range(0, 11) == 0);
         irq           = ($urandom_range(0, 9) == 0);
         step();
      end
      rst_n = 1'b1;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
